barrido_display: RTL and testbench

BARRIDO_DISPLAY -- requirements
Module: barrido_display

---
 rtl/barrido_display_pkg.sv | 27 ++
 rtl/bcd_a_7seg.sv | 33 +++
 rtl/barrido_display.sv | 114 +++++++++++
 tb/tb_barrido_display.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/barrido_display_pkg.sv
// Shared constants for the multiplexed 4-digit 7-segment display scanner.
// Segment patterns are ordered {a,b,c,d,e,f,g} and are active-low.
package barrido_display_pkg;

    localparam int DIV_DEFAULT = 50000;

    localparam logic [3:0] AN_OFF = 4'b1111;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low one-hot anode pattern for a slot; slot 0 is the leftmost digit on an[3].
    function automatic logic [3:0] an_for_slot(input logic [1:0] slot);
        return ~(4'b1000 >> slot);
    endfunction

endpackage

// File: rtl/bcd_a_7seg.sv
// Combinational BCD to 7-segment encoder (active-low segments).
// Codes A-F show a dash; 'blank' overrides everything and turns all segments off.
module bcd_a_7seg
    import barrido_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Map the nibble to its segment pattern, with blanking taking priority
    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/barrido_display.sv
// Four-digit multiplexed 7-segment display scanner.
// A prescaler divides clk into digit slots; the BCD value is captured once per
// full scan (on the 3->0 wrap) so a display refresh is always self-consistent.
module barrido_display
    import barrido_display_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] bcd,
    input  logic        blank_lz,
    input  logic [3:0]  dp_mask,
    output logic [1:0]  digito,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        tick
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc;
    logic [15:0]   snapshot;
    logic          advance;
    logic [3:0]    nibble;
    logic          lead_zero;
    logic          blank_digit;
    logic          dp_bit;
    logic [6:0]    seg_next;
    logic          zero0;
    logic          zero01;
    logic          zero012;

    assign advance = en && (presc == LAST);

    // Slot timing: prescaler, slot index, per-scan snapshot and the advance pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc    <= '0;
            digito   <= 2'd0;
            snapshot <= 16'h0000;
            tick     <= 1'b0;
        end else begin
            tick <= advance;
            if (en) begin
                if (advance) begin
                    presc  <= '0;
                    digito <= digito + 2'd1;
                    if (digito == 2'd3) begin
                        snapshot <= bcd;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    // Pick the nibble, leading-zero flag and decimal point for the current slot
    always_comb begin
        zero0       = (snapshot[15:12] == 4'd0);
        zero01      = zero0  && (snapshot[11:8] == 4'd0);
        zero012     = zero01 && (snapshot[7:4]  == 4'd0);
        nibble      = snapshot[3:0];
        lead_zero   = 1'b0;
        dp_bit      = dp_mask[0];
        case (digito)
            2'd0: begin
                nibble    = snapshot[15:12];
                lead_zero = zero0;
                dp_bit    = dp_mask[3];
            end
            2'd1: begin
                nibble    = snapshot[11:8];
                lead_zero = zero01;
                dp_bit    = dp_mask[2];
            end
            2'd2: begin
                nibble    = snapshot[7:4];
                lead_zero = zero012;
                dp_bit    = dp_mask[1];
            end
            default: begin
                nibble    = snapshot[3:0];
                lead_zero = 1'b0;
                dp_bit    = dp_mask[0];
            end
        endcase
        blank_digit = blank_lz && lead_zero;
    end

    bcd_a_7seg u_enc (
        .bcd   (nibble),
        .blank (blank_digit),
        .seg   (seg_next)
    );

    // Register the display drive so an/seg/dp change together, one cycle after the slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= en ? an_for_slot(digito) : AN_OFF;
            seg <= seg_next;
            dp  <= ~dp_bit;
        end
    end

endmodule

// File: tb/tb_barrido_display.sv
// Self-checking bench for barrido_display with DIV=4.
// The reference model counts enabled cycles since reset and derives the slot,
// snapshot and expected display drive from that count with plain arithmetic.
module tb_barrido_display;

    localparam int DIV = 4;

    localparam logic [6:0] PAT [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] bcd;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [1:0]  digito;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        tick;

    int          errors = 0;
    int          checks = 0;

    int          mCnt = 0;
    logic [15:0] mSnap = 16'h0000;
    logic [1:0]  expDig = 2'd0;
    logic [3:0]  expAn = 4'b1111;
    logic [6:0]  expSeg = 7'b1111111;
    logic        expDp = 1'b1;
    logic        expTick = 1'b0;

    barrido_display #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .bcd      (bcd),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .digito   (digito),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected segments for digit d of snapshot s, from the display rules directly
    function automatic logic [6:0] refSeg(input logic [15:0] s, input int d, input logic lz);
        logic [3:0] nib;
        logic       allZero;
        nib = 4'((s >> (4 * (3 - d))) & 16'h000F);
        allZero = 1'b1;
        for (int k = 0; k <= d; k++) begin
            if (((s >> (4 * (3 - k))) & 16'h000F) != 16'h0000) allZero = 1'b0;
        end
        if (lz && d < 3 && allZero) return 7'b1111111;
        if (nib > 4'd9) return 7'b1111110;
        return PAT[nib];
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    task automatic modelStep();
        int curDig;
        logic adv;
        if (!rst_n) begin
            mCnt    = 0;
            mSnap   = 16'h0000;
            expAn   = 4'b1111;
            expSeg  = 7'b1111111;
            expDp   = 1'b1;
            expTick = 1'b0;
        end else begin
            curDig  = (mCnt / DIV) % 4;
            expAn   = en ? ~(4'b1000 >> curDig) : 4'b1111;
            expSeg  = refSeg(mSnap, curDig, blank_lz);
            expDp   = ~dp_mask[3 - curDig];
            adv     = en && (mCnt % DIV == DIV - 1);
            expTick = adv;
            if (en) begin
                if (adv && curDig == 3) mSnap = bcd;
                mCnt = (mCnt + 1) % (4 * DIV);
            end
        end
        expDig = 2'((mCnt / DIV) % 4);
    endtask

    // Drive one cycle of inputs at the falling edge, step the model, check the outputs
    task automatic applyStimulus(input logic rIn, input logic eIn, input logic [15:0] bIn,
                                 input logic lzIn, input logic [3:0] mIn);
        rst_n    = rIn;
        en       = eIn;
        bcd      = bIn;
        blank_lz = lzIn;
        dp_mask  = mIn;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput("digito", 32'(digito), 32'(expDig));
        checkOutput("an",     32'(an),     32'(expAn));
        checkOutput("seg",    32'(seg),    32'(expSeg));
        checkOutput("dp",     32'(dp),     32'(expDp));
        checkOutput("tick",   32'(tick),   32'(expTick));
    endtask

    function automatic logic [15:0] randBcd();
        logic [15:0] v;
        v = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            v = (v << 4) | ((($urandom % 3) == 0) ? 16'h0 : 16'($urandom % 16));
        end
        return v;
    endfunction

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        bcd      = 16'h0000;
        blank_lz = 1'b0;
        dp_mask  = 4'b0000;
        @(negedge clk);

        $display("[TB] reset and first scan on an empty snapshot");
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 16'h1234, 1'b1, 4'b0000);
        checkOutput("reset_seg_literal", 32'(seg), 32'(7'b1111111));
        checkOutput("reset_an_literal",  32'(an),  32'(4'b1111));
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 16'h1234, 1'b1, 4'b0000);

        $display("[TB] 1234 without blanking");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 4'b0100);

        $display("[TB] leading-zero blanking patterns");
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b1, 16'h0005, 1'b1, 4'b0001);
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b1, 16'h0000, 1'b1, 4'b1010);
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b1, 16'h0A00, 1'b1, 4'b0000);

        $display("[TB] bcd changing mid-scan");
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b1, randBcd(), 1'b0, 4'($urandom));

        $display("[TB] enable dropped on the last prescaler count");
        for (int i = 0; i < 8 && (mCnt % DIV) != DIV - 1; i++)
            applyStimulus(1'b1, 1'b1, 16'h9876, 1'b1, 4'b0000);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 16'h9876, 1'b1, 4'b0000);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 16'h9876, 1'b1, 4'b0000);

        $display("[TB] reset in the middle of a slot");
        for (int i = 0; i < 8 && (mCnt % DIV) != 2; i++)
            applyStimulus(1'b1, 1'b1, 16'h4321, 1'b0, 4'b1111);
        applyStimulus(1'b0, 1'b1, 16'h4321, 1'b0, 4'b1111);
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, 1'b1, 16'h4321, 1'b0, 4'b1111);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom % 64) != 0, ($urandom % 6) != 0,
                          (($urandom % 4) == 0) ? randBcd() : bcd,
                          1'($urandom), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
